// File: rtl/cpu_pkg.sv
// Shared CPU core constants and types: default register-file geometry and the
// hard-wired zero register index.
package cpu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register pending-write scoreboard: issue sets a bit, writeback clears it,
// flush squashes everything. Also keeps a registered population count.
module regfile_busy_tracker
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  flush,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [ADDR_W:0]       busy_count
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0] busy_d, busy_q;
  logic [CW-1:0]    count_d, count_q;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      // Clear before set so a same-cycle issue to the written register wins.
      if (wr_en)    busy_d[wr_addr]    = 1'b0;
      if (issue_en) busy_d[issue_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[ADDR_W'(REG_ZERO)] = 1'b0;

    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with combinational read ports, write-to-read
// bypass and a busy scoreboard for the hazard unit.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  output logic [NUM_READ-1:0]        rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       flush,
  output logic [ADDR_W:0]            busy_count
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic              wr_zero;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO));

  always_comb begin
    regs_d = regs_q;
    if (wr_en && !wr_zero) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_busy_tracker #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk        (clk),
    .reset_n    (reset_n),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .flush      (flush),
    .busy       (busy_vec),
    .busy_count (busy_count)
  );

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              is_byp;

    assign addr    = rd_addr[gi*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
    assign is_byp  = (BYPASS != 0) && wr_en && (wr_addr == addr);

    // Reset gating keeps the bypass path from leaking wr_data while held in reset.
    assign rd_data[gi*DATA_W +: DATA_W] = (!reset_n || is_zero) ? '0 :
                                          is_byp ? wr_data : regs_q[addr];
    assign rd_busy[gi] = reset_n && !is_zero && !is_byp && busy_vec[addr];
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scenario bench for regfile_scoreboard: expectations are queued as stimulus is
// driven and popped against the DUT outputs at each sample point.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        flush;
  logic [5:0]  busy_count;

  localparam int K_D0 = 0, K_D1 = 1, K_B0 = 2, K_B1 = 3, K_CNT = 4;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] obs;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .busy_count (busy_count)
  );

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_D0:    return rd_data[31:0];
      K_D1:    return rd_data[63:32];
      K_B0:    return {31'b0, rd_busy[0]};
      K_B1:    return {31'b0, rd_busy[1]};
      default: return {26'b0, busy_count};
    endcase
  endfunction

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    exp_t x;
    x.kind = kind; x.exp = exp; x.name = name;
    sb.push_back(x);
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_addr = 0; flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[4:0] = 5'(a0);
    rd_addr[9:5] = 5'(a1);
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); set_rd(5, 5);
    wr_en = 1; wr_addr = 5; wr_data = 32'h99; issue_en = 1; issue_addr = 5;
    #3;
    push(K_D0, 0, "rst_bypass_d0"); push(K_D1, 0, "rst_bypass_d1");
    push(K_B0, 0, "rst_busy0"); push(K_CNT, 0, "rst_count");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    cyc();
    push(K_CNT, 0, "rst_count_edge");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    @(negedge clk); reset_n = 1; idle();
    for (int a = 0; a < 32; a++) begin
      cyc(); set_rd(a, 31 - a); #2;
      push(K_D0, 0, $sformatf("post_rst_d0_r%0d", a));
      push(K_D1, 0, $sformatf("post_rst_d1_r%0d", 31 - a));
      push(K_B0, 0, $sformatf("post_rst_b0_r%0d", a));
      push(K_B1, 0, $sformatf("post_rst_b1_r%0d", 31 - a));
      push(K_CNT, 0, "post_rst_count");
      while (sb.size() > 0) begin
        e = sb.pop_front(); obs = observe(e.kind); checks++;
        if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
      end
    end
  endtask

  task automatic test_bypass();
    cyc(); idle(); set_rd(5, 5);
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; #2;
    push(K_D0, 32'hDEADBEEF, "bypass_d0"); push(K_D1, 32'hDEADBEEF, "bypass_d1");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    cyc(); idle(); #2;
    push(K_D0, 32'hDEADBEEF, "stored_d0");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    cyc(); set_rd(0, 5); wr_en = 1; wr_addr = 0; wr_data = 32'h1234; #2;
    push(K_D0, 0, "r0_bypass_blocked"); push(K_D1, 32'hDEADBEEF, "r5_other_port");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    cyc(); idle(); #2;
    push(K_D0, 0, "r0_after_write");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_busy();
    cyc(); idle(); set_rd(7, 9); issue_en = 1; issue_addr = 7;
    cyc(); issue_addr = 9; #2;
    push(K_CNT, 1, "count_after_r7"); push(K_B0, 1, "r7_busy"); push(K_B1, 0, "r9_not_yet");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    cyc(); idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h55; #2;
    push(K_CNT, 2, "count_after_r9"); push(K_B0, 0, "r7_busy_bypassed");
    push(K_D0, 32'h55, "r7_bypass_data"); push(K_B1, 1, "r9_busy");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    cyc(); idle(); #2;
    push(K_CNT, 1, "count_after_wb_r7"); push(K_B0, 0, "r7_cleared"); push(K_D0, 32'h55, "r7_data");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_same_cycle();
    // busy set on entry: r9
    cyc(); idle(); set_rd(3, 9);
    issue_en = 1; issue_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'h77;
    cyc(); idle(); #2;
    push(K_B0, 1, "r3_issue_wins"); push(K_D0, 32'h77, "r3_data"); push(K_CNT, 2, "count_r9_r3");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    issue_en = 1; issue_addr = 6;
    cyc(); idle(); set_rd(4, 6);
    issue_en = 1; issue_addr = 4; wr_en = 1; wr_addr = 6; wr_data = 32'h66;
    cyc(); idle(); #2;
    push(K_B0, 1, "r4_busy"); push(K_B1, 0, "r6_cleared");
    push(K_D1, 32'h66, "r6_data"); push(K_CNT, 3, "count_r9_r3_r4");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    // WAW on r4, write to idle r12, issue to r0: none may change the count
    issue_en = 1; issue_addr = 4;
    cyc(); issue_addr = 0; wr_en = 1; wr_addr = 12; wr_data = 32'hC;
    cyc(); idle(); set_rd(0, 12); #2;
    push(K_CNT, 3, "count_waw_r0"); push(K_B0, 0, "r0_never_busy");
    push(K_B1, 0, "r12_not_busy"); push(K_D1, 32'hC, "r12_data");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_flush();
    issue_en = 1; issue_addr = 1;
    cyc(); issue_addr = 2;
    cyc(); idle(); #2;
    push(K_CNT, 5, "count_before_flush");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    flush = 1; issue_en = 1; issue_addr = 8; wr_en = 1; wr_addr = 20; wr_data = 32'h2020;
    cyc(); idle(); set_rd(8, 20); #2;
    push(K_CNT, 0, "count_after_flush"); push(K_B0, 0, "r8_issue_dropped");
    push(K_D1, 32'h2020, "flush_write_kept");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_async_reset();
    wr_en = 1; wr_addr = 10; wr_data = 32'hAA;
    cyc(); idle(); issue_en = 1; issue_addr = 10;
    cyc(); idle(); set_rd(10, 10); #2;
    push(K_D0, 32'hAA, "r10_data"); push(K_B0, 1, "r10_busy"); push(K_CNT, 1, "count_r10");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    reset_n = 0; #1;
    push(K_D0, 0, "async_rst_data"); push(K_B0, 0, "async_rst_busy"); push(K_CNT, 0, "async_rst_count");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
    wr_en = 1; wr_addr = 10; wr_data = 32'hBB; issue_en = 1; issue_addr = 10;
    cyc(); @(negedge clk); reset_n = 1; idle(); #1;
    push(K_D0, 0, "rst_write_lost"); push(K_B0, 0, "rst_issue_lost"); push(K_CNT, 0, "rst_count_held");
    while (sb.size() > 0) begin
      e = sb.pop_front(); obs = observe(e.kind); checks++;
      if (obs !== e.exp) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  initial begin
    reset_n = 0; rd_addr = '0; idle();
    test_reset();
    test_bypass();
    test_busy();
    test_same_cycle();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
